// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out bundle for pulse_stretcher.
// master drives the event strobe and overflow clear; slave returns window status.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              pulse_in;
    logic              clr_ovf;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              ovf;

    modport master (
        output pulse_in,
        output clr_ovf,
        input  out,
        input  busy,
        input  pend,
        input  ovf
    );

    modport slave (
        input  pulse_in,
        input  clr_ovf,
        output out,
        output busy,
        output pend,
        output ovf
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle events into ON_CYCLES-high windows followed by an OFF_CYCLES gap; extra events queue.
// Optional macro PULSE_STRETCHER_RETRIG_EN: pulses during ON extend the current window instead of queueing.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 10,
    parameter int OFF_CYCLES = 10,
    parameter int CNT_W      = 16,
    parameter int PEND_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    pulse_stretcher_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ON_LD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LD   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;
    logic              r_out;
    logic              r_busy;

    state_t            w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [PEND_W-1:0] w_nxt_pend;
    logic              w_ovf_set;
    logic [PEND_W:0]   w_eff;
    logic              w_pend_max;

    assign w_pend_max = (r_pend == PEND_MAX);
    assign w_eff      = {1'b0, r_pend} + {{PEND_W{1'b0}}, bus.pulse_in};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_pend  = r_pend;
        w_ovf_set   = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt_pend = '0;
                if (bus.pulse_in) begin
                    w_nxt_state = ON;
                    w_nxt_cnt   = ON_LD;
                end
            end
            ON: begin
`ifdef PULSE_STRETCHER_RETRIG_EN
                if (bus.pulse_in) begin
                    w_nxt_cnt = ON_LD;
                end else if (r_cnt == '0) begin
                    w_nxt_state = OFF;
                    w_nxt_cnt   = OFF_LD;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
`else
                if (bus.pulse_in) begin
                    if (w_pend_max) w_ovf_set  = 1'b1;
                    else            w_nxt_pend = r_pend + 1'b1;
                end
                if (r_cnt == '0) begin
                    w_nxt_state = OFF;
                    w_nxt_cnt   = OFF_LD;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
`endif
            end
            OFF: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - 1'b1;
                    if (bus.pulse_in) begin
                        if (w_pend_max) w_ovf_set  = 1'b1;
                        else            w_nxt_pend = r_pend + 1'b1;
                    end
                // Last gap cycle: a same-cycle pulse counts toward the replay, so a full queue never overflows here.
                end else if (w_eff != '0) begin
                    w_nxt_state = ON;
                    w_nxt_cnt   = ON_LD;
                    w_nxt_pend  = PEND_W'(w_eff - 1'b1);
                end else begin
                    w_nxt_state = IDLE;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
                w_nxt_pend  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_pend  <= w_nxt_pend;
            r_out   <= (w_nxt_state == ON);
            r_busy  <= (w_nxt_state != IDLE);
            if (w_ovf_set)        r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;
    assign bus.pend = r_pend;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a phase/elapsed-time model predicts each cycle's outputs.
module tb_pulse_stretcher;
    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PW   = 2;
    localparam int CW   = 4;
    localparam int QMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_stretcher_if #(.PEND_W(PW)) bus();

    pulse_stretcher #(
        .ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(CW), .PEND_W(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic o;
        logic b;
        int   p;
        logic v;
    } exp_t;

    exp_t sb[$];

    int   m_ph;   // 0 idle, 1 on, 2 off
    int   m_t;    // cycles already spent in current phase
    int   m_q;
    logic m_ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    int   sum_out;
    int   sum_busy;
    logic obs_out;
    logic obs_busy;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_step(input logic p, input logic c, input logic r);
        logic set;
        int   n;
        set = 1'b0;
        if (!r) begin
            m_ph = 0; m_t = 0; m_q = 0; m_ovf = 1'b0;
        end else begin
            case (m_ph)
                0: if (p) begin m_ph = 1; m_t = 0; end
                1: begin
`ifdef PULSE_STRETCHER_RETRIG_EN
                    if (p) m_t = 0;
                    else if (m_t == ON - 1) begin m_ph = 2; m_t = 0; end
                    else m_t++;
`else
                    if (p) begin
                        if (m_q == QMAX) set = 1'b1; else m_q++;
                    end
                    if (m_t == ON - 1) begin m_ph = 2; m_t = 0; end
                    else m_t++;
`endif
                end
                default: begin
                    if (m_t == OFF - 1) begin
                        n = m_q + (p ? 1 : 0);
                        if (n > 0) begin m_ph = 1; m_t = 0; m_q = n - 1; end
                        else begin m_ph = 0; m_t = 0; end
                    end else begin
                        if (p) begin
                            if (m_q == QMAX) set = 1'b1; else m_q++;
                        end
                        m_t++;
                    end
                end
            endcase
            if (set)    m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
    endtask

    task automatic tick(input logic p, input logic c, input logic r);
        exp_t e;
        bus.pulse_in = p;
        bus.clr_ovf  = c;
        rst          = r;
        model_step(p, c, r);
        e.o = (m_ph == 1);
        e.b = (m_ph != 0);
        e.p = m_q;
        e.v = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("out",  int'(bus.out),  int'(e.o));
        check_val("busy", int'(bus.busy), int'(e.b));
        check_val("pend", int'(bus.pend), e.p);
        check_val("ovf",  int'(bus.ovf),  int'(e.v));
        obs_out  = bus.out;
        obs_busy = bus.busy;
        sum_out  += int'(bus.out);
        sum_busy += int'(bus.busy);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (obs_busy !== 1'b0 && k < limit) begin
            tick(1'b0, 1'b0, 1'b1);
            k++;
        end
        if (obs_busy !== 1'b0) check_val("drain_timeout", 1, 0);
    endtask

    initial begin
        bus.pulse_in = 1'b0;
        bus.clr_ovf  = 1'b0;
        rst          = 1'b0;
        m_ph = 0; m_t = 0; m_q = 0; m_ovf = 1'b0;
        sum_out = 0; sum_busy = 0;

        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // single event: 4 high cycles, 7 busy cycles
        sum_out = 0; sum_busy = 0;
        tick(1'b1, 1'b0, 1'b1);
        repeat (9) tick(1'b0, 1'b0, 1'b1);
        check_val("t1_out_len",  sum_out,  ON);
        check_val("t1_busy_len", sum_busy, ON + OFF);

        // three back-to-back events replay as three windows, busy ends after cycle 21
        sum_out = 0; sum_busy = 0;
        repeat (3) tick(1'b1, 1'b0, 1'b1);
        repeat (22) tick(1'b0, 1'b0, 1'b1);
        check_val("t2_out_len",  sum_out,  3 * ON);
        check_val("t2_busy_len", sum_busy, 21);

        // saturation, overflow, clear, set-beats-clear
        repeat (5) tick(1'b1, 1'b0, 1'b1);
        check_val("t3_ovf_set", int'(bus.ovf), 1);
        tick(1'b0, 1'b1, 1'b1);
        check_val("t3_ovf_clr", int'(bus.ovf), 0);
        tick(1'b1, 1'b1, 1'b1);
        check_val("t3_ovf_prio", int'(bus.ovf), 1);
        drain(80);
        tick(1'b0, 1'b1, 1'b1);

        // pulse on the last gap cycle restarts ON without an idle cycle
        tick(1'b1, 1'b0, 1'b1);
        repeat (6) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check_val("t4_rearm", int'(obs_out), 1);
        drain(40);

        // reset in the middle of a window with queued events
        repeat (3) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check_val("t5_busy", int'(obs_busy), 0);
        sum_out = 0;
        tick(1'b1, 1'b0, 1'b1);
        drain(40);
        check_val("t5_out_len", sum_out, ON);

`ifdef PULSE_STRETCHER_RETRIG_EN
        sum_out = 0; sum_busy = 0;
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b1);
        check_val("t6_out_len",  sum_out,  7);
        check_val("t6_busy_len", sum_busy, 10);
`endif

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) != 0));
        end
        tick(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
